// File: rtl/imhotep_pkg.sv
// Shared types and sizing for the imhotep data memory.
// Holds the access-width and data-memory state encodings plus a helper
// that converts an access width to its size in bytes.
package imhotep_pkg;

  localparam int XLEN      = 32;
  localparam int RAM_WIDTH = 16;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } mem_width_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } dmem_state_e;

  // Number of bytes touched by an access of the given width (0 for reserved).
  function automatic logic [2:0] width_bytes(input mem_width_e width);
    logic [2:0] size;
    case (width)
      BYTE:    size = 3'd1;
      HALF:    size = 3'd2;
      WORD:    size = 3'd4;
      default: size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane alignment for the data memory.
// Produces byte enables and lane-shifted store data across a pair of
// consecutive words (bits [3:0]/[31:0] low word, [7:4]/[63:32] high word),
// and the right-justified, extended load value from that word pair.
module dmem_lane_align
  import imhotep_pkg::*;
(
  input  logic [1:0]  offset,
  input  mem_width_e  width,
  input  logic        zero_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [7:0]  byte_en,
  output logic [63:0] store_lanes,
  output logic [31:0] load_data
);

  logic [7:0]       mask_s;
  logic [7:0][7:0]  pair_s;
  logic [3:0][7:0]  raw_s;

  // Build enables/store lanes and pick the addressed bytes out of the pair.
  always_comb begin
    mask_s      = 8'h00;
    pair_s      = {hi_word, lo_word};
    raw_s       = 32'h0000_0000;
    load_data   = 32'h0000_0000;

    case (width)
      BYTE:    mask_s = 8'h01;
      HALF:    mask_s = 8'h03;
      WORD:    mask_s = 8'h0F;
      default: mask_s = 8'h00;
    endcase

    byte_en     = mask_s << offset;
    store_lanes = {32'h0000_0000, store_data} << {offset, 3'b000};

    for (int i = 0; i < 4; i++) begin
      raw_s[i] = pair_s[{1'b0, offset} + 3'(i)];
    end

    case (width)
      BYTE: begin
        if (zero_ext) begin
          load_data = {24'h00_0000, raw_s[0]};
        end else begin
          load_data = {{24{raw_s[0][7]}}, raw_s[0]};
        end
      end
      HALF: begin
        if (zero_ext) begin
          load_data = {16'h0000, raw_s[1], raw_s[0]};
        end else begin
          load_data = {{16{raw_s[1][7]}}, raw_s[1], raw_s[0]};
        end
      end
      WORD:    load_data = raw_s;
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem.sv
// Byte-addressed, little-endian data memory with a valid/ready request
// port and a one-cycle response pulse.
// Optional macro DMEM_MISALIGNED_EN: when defined, misaligned accesses are
// serviced (word-crossing ones take an extra SPLIT cycle); when undefined,
// every misaligned access returns an error and no SPLIT cycle ever occurs.
module dmem
  import imhotep_pkg::*;
#(
  parameter int ADDR_W = RAM_WIDTH,
  parameter int DATA_W = XLEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              w_rn_i,
  input  logic [1:0]        width_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int WORDS = 2 ** IDX_W;

`ifdef DMEM_MISALIGNED_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  // Storage: one packed 4-lane word per index, never reset.
  logic [3:0][7:0] mem_r [WORDS];

  dmem_state_e state_r, state_nxt_s;

  // Request captured for the second half of a word-crossing access.
  logic [IDX_W-1:0] cap_idx_r;
  logic [1:0]       cap_off_r;
  mem_width_e       cap_width_r;
  logic             cap_uns_r;
  logic             cap_wr_r;
  logic [31:0]      cap_data_r;
  logic [31:0]      lo_r;

  logic             rsp_valid_r, rsp_err_r;
  logic [31:0]      data_r;

  logic             rsp_valid_nxt_s, rsp_err_nxt_s;
  logic [31:0]      data_nxt_s;
  logic             capture_s;

  logic [IDX_W-1:0] req_idx_s, hi_idx_s;
  logic [1:0]       req_off_s;
  mem_width_e       req_width_s;
  logic             accept_s, crossing_s, misaligned_s, err_s;
  logic [2:0]       size_s;

  logic             wr_en_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [3:0]       wr_be_s;
  logic [31:0]      wr_data_s;

  logic [1:0]       al_off_s;
  mem_width_e       al_width_s;
  logic             al_uns_s;
  logic [31:0]      al_sdata_s, al_lo_s, al_hi_s, al_load_s;
  logic [7:0]       al_be_s;
  logic [63:0]      al_wdata_s;

  assign req_ready_o = (state_r == IDLE);
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_err_o   = rsp_err_r;
  assign data_o      = data_r;

  assign req_idx_s   = addr_i[ADDR_W-1:2];
  assign req_off_s   = addr_i[1:0];
  assign req_width_s = mem_width_e'(width_i);
  assign hi_idx_s    = cap_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
  assign accept_s    = req_valid_i & req_ready_o;

  // Classify the incoming request: size, word crossing, alignment, error.
  always_comb begin
    size_s       = width_bytes(req_width_s);
    crossing_s   = (({2'b00, req_off_s} + {1'b0, size_s}) > 4'd4);
    misaligned_s = ((req_width_s == HALF) && req_off_s[0]) ||
                   ((req_width_s == WORD) && (req_off_s != 2'b00));
    err_s        = (req_width_s == RSVD) || (misaligned_s && !MISALIGN_EN);
  end

  // Feed the aligner with the live request in IDLE, the captured one in SPLIT.
  always_comb begin
    al_off_s   = req_off_s;
    al_width_s = req_width_s;
    al_uns_s   = unsigned_i;
    al_sdata_s = data_i;
    al_lo_s    = mem_r[req_idx_s];
    al_hi_s    = 32'h0000_0000;
    if (state_r == SPLIT) begin
      al_off_s   = cap_off_r;
      al_width_s = cap_width_r;
      al_uns_s   = cap_uns_r;
      al_sdata_s = cap_data_r;
      al_lo_s    = lo_r;
      al_hi_s    = mem_r[hi_idx_s];
    end else begin
      al_hi_s    = 32'h0000_0000;
    end
  end

  dmem_lane_align u_align (
    .offset      (al_off_s),
    .width       (al_width_s),
    .zero_ext    (al_uns_s),
    .store_data  (al_sdata_s),
    .lo_word     (al_lo_s),
    .hi_word     (al_hi_s),
    .byte_en     (al_be_s),
    .store_lanes (al_wdata_s),
    .load_data   (al_load_s)
  );

  // Next state, next response and the memory write port.
  always_comb begin
    state_nxt_s     = state_r;
    rsp_valid_nxt_s = 1'b0;
    rsp_err_nxt_s   = 1'b0;
    data_nxt_s      = 32'h0000_0000;
    capture_s       = 1'b0;
    wr_en_s         = 1'b0;
    wr_idx_s        = req_idx_s;
    wr_be_s         = 4'h0;
    wr_data_s       = 32'h0000_0000;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (err_s) begin
            rsp_valid_nxt_s = 1'b1;
            rsp_err_nxt_s   = 1'b1;
          end else if (MISALIGN_EN && crossing_s) begin
            state_nxt_s = SPLIT;
            capture_s   = 1'b1;
            wr_en_s     = w_rn_i;
            wr_be_s     = al_be_s[3:0];
            wr_data_s   = al_wdata_s[31:0];
          end else begin
            rsp_valid_nxt_s = 1'b1;
            wr_en_s         = w_rn_i;
            wr_be_s         = al_be_s[3:0];
            wr_data_s       = al_wdata_s[31:0];
            if (w_rn_i) begin
              data_nxt_s = 32'h0000_0000;
            end else begin
              data_nxt_s = al_load_s;
            end
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SPLIT: begin
        state_nxt_s     = IDLE;
        rsp_valid_nxt_s = 1'b1;
        wr_en_s         = cap_wr_r;
        wr_idx_s        = hi_idx_s;
        wr_be_s         = al_be_s[7:4];
        wr_data_s       = al_wdata_s[63:32];
        if (cap_wr_r) begin
          data_nxt_s = 32'h0000_0000;
        end else begin
          data_nxt_s = al_load_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, response and split-capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      data_r      <= 32'h0000_0000;
      cap_idx_r   <= {IDX_W{1'b0}};
      cap_off_r   <= 2'b00;
      cap_width_r <= BYTE;
      cap_uns_r   <= 1'b0;
      cap_wr_r    <= 1'b0;
      cap_data_r  <= 32'h0000_0000;
      lo_r        <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      data_r      <= data_nxt_s;
      if (capture_s) begin
        cap_idx_r   <= req_idx_s;
        cap_off_r   <= req_off_s;
        cap_width_r <= req_width_s;
        cap_uns_r   <= unsigned_i;
        cap_wr_r    <= w_rn_i;
        cap_data_r  <= data_i;
        lo_r        <= mem_r[req_idx_s];
      end
    end
  end

  // Byte-lane memory writes; contents survive reset, writes blocked during it.
  always_ff @(posedge clk) begin
    if (wr_en_s && reset_n) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) begin
          mem_r[wr_idx_s][b] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem.sv
// Self-checking bench for dmem: directed scenarios plus randomized traffic
// checked against a byte-array reference model.
module tb_dmem;

`ifdef DMEM_MISALIGNED_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        w_rn_i = 1'b0;
  logic [1:0]  width_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic [15:0] addr_i = 16'h0000;
  logic [31:0] data_i = 32'h0;
  logic        rsp_valid_o;
  logic        rsp_err_o;
  logic [31:0] data_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [0:65535];

  always #5 clk = ~clk;

  dmem dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .w_rn_i      (w_rn_i),
    .width_i     (width_i),
    .unsigned_i  (unsigned_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_err_o   (rsp_err_o),
    .data_o      (data_o)
  );

  // Reference model: byte-array memory, computes error/data/latency.
  function automatic void model(input logic w, input logic [1:0] wd, input logic u,
                                input logic [15:0] a, input logic [31:0] d,
                                output logic e, output logic [31:0] q, output int lat);
    int sz;
    bit mis;
    logic [31:0] v;
    sz  = (wd == 2'd0) ? 1 : (wd == 2'd1) ? 2 : 4;
    mis = (wd == 2'd1 && a[0]) || (wd == 2'd2 && a[1:0] != 2'd0);
    q = 32'h0;
    if (wd == 2'd3 || (mis && !MIS_EN)) begin
      e = 1'b1;
      lat = 1;
      return;
    end
    e = 1'b0;
    lat = ((int'(a[1:0]) + sz) > 4) ? 2 : 1;
    if (w) begin
      for (int i = 0; i < sz; i++) ref_mem[16'(a + 16'(i))] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[16'(a + 16'(i))];
      if (!u && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!u && sz == 2) v = {{16{v[15]}}, v[15:0]};
      q = v;
    end
  endfunction

  // Issue one request from a negedge; return latency, response and busy cycles.
  task automatic do_req(input logic w, input logic [1:0] wd, input logic u,
                        input logic [15:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] q,
                        output int busy);
    req_valid_i = 1'b1; w_rn_i = w; width_i = wd; unsigned_i = u; addr_i = a; data_i = d;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    lat = 0; busy = 0; e = 1'b0; q = 32'h0;
    while (lat < 4) begin
      @(negedge clk);
      lat++;
      if (rsp_valid_o) begin
        e = rsp_err_o;
        q = data_o;
        break;
      end
      if (!req_ready_o) begin
        busy++;
        // A stray store while busy must be ignored.
        req_valid_i = 1'b1; w_rn_i = 1'b1; width_i = 2'b10; addr_i = 16'h0020;
        data_i = $urandom;
      end else begin
        req_valid_i = 1'b0;
      end
    end
    if (lat >= 4 && !rsp_valid_o) lat = 99;
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || data_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b e=%b d=%h, want 0/0/0", rsp_valid_o, rsp_err_o, data_o);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b, want 1", req_ready_o);
    end
  endtask

  task automatic test_prefill;
    int lat, busy, elat; logic e, ee; logic [31:0] q, eq, d; logic [15:0] a;
    for (int k = 0; k < 36; k++) begin
      if (k < 16)      a = 16'(4 * k);
      else if (k < 32) a = 16'hFFC0 + 16'(4 * (k - 16));
      else if (k == 32) a = 16'h1000;
      else if (k == 33) a = 16'h2000;
      else if (k == 34) a = 16'h3000;
      else              a = 16'h3004;
      d = $urandom;
      model(1'b1, 2'b10, 1'b0, a, d, ee, eq, elat);
      do_req(1'b1, 2'b10, 1'b0, a, d, lat, e, q, busy);
      checks++;
      if (e !== ee || lat !== elat) begin
        failures++;
        $display("FAIL prefill @%h: got err=%b lat=%0d, want err=%b lat=%0d", a, e, lat, ee, elat);
      end
    end
  endtask

  task automatic test_word;
    int lat, busy; logic e; logic [31:0] q;
    do_req(1'b1, 2'b10, 1'b0, 16'h1000, 32'hDEADBEEF, lat, e, q, busy);
    ref_mem[16'h1000] = 8'hEF; ref_mem[16'h1001] = 8'hBE;
    ref_mem[16'h1002] = 8'hAD; ref_mem[16'h1003] = 8'hDE;
    checks++;
    if (lat !== 1 || e !== 1'b0 || q !== 32'h0) begin
      failures++;
      $display("FAIL word_store: got lat=%0d err=%b d=%h, want 1/0/0", lat, e, q);
    end
    do_req(1'b0, 2'b10, 1'b0, 16'h1000, 32'h0, lat, e, q, busy);
    checks++;
    if (lat !== 1 || e !== 1'b0 || q !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_load: got lat=%0d err=%b d=%h, want 1/0/deadbeef", lat, e, q);
    end
  endtask

  task automatic test_byte;
    int lat, busy; logic e; logic [31:0] q;
    do_req(1'b1, 2'b00, 1'b0, 16'h2001, 32'h0000_0080, lat, e, q, busy);
    ref_mem[16'h2001] = 8'h80;
    checks++;
    if (lat !== 1 || e !== 1'b0) begin
      failures++;
      $display("FAIL byte_store: got lat=%0d err=%b, want 1/0", lat, e);
    end
    do_req(1'b0, 2'b00, 1'b0, 16'h2001, 32'h0, lat, e, q, busy);
    checks++;
    if (q !== 32'hFFFFFF80 || e !== 1'b0) begin
      failures++;
      $display("FAIL byte_load_signed: got %h err=%b, want ffffff80/0", q, e);
    end
    do_req(1'b0, 2'b00, 1'b1, 16'h2001, 32'h0, lat, e, q, busy);
    checks++;
    if (q !== 32'h00000080) begin
      failures++;
      $display("FAIL byte_load_unsigned: got %h, want 00000080", q);
    end
    do_req(1'b0, 2'b00, 1'b1, 16'h2000, 32'h0, lat, e, q, busy);
    checks++;
    if (q !== {24'h0, ref_mem[16'h2000]}) begin
      failures++;
      $display("FAIL byte_neighbor_lo: got %h, want %h", q, ref_mem[16'h2000]);
    end
    do_req(1'b0, 2'b00, 1'b1, 16'h2002, 32'h0, lat, e, q, busy);
    checks++;
    if (q !== {24'h0, ref_mem[16'h2002]}) begin
      failures++;
      $display("FAIL byte_neighbor_hi: got %h, want %h", q, ref_mem[16'h2002]);
    end
  endtask

  task automatic test_misaligned;
    int lat, busy; logic e; logic [31:0] q, w0, w1;
    w0 = {ref_mem[16'h3003], ref_mem[16'h3002], ref_mem[16'h3001], ref_mem[16'h3000]};
    w1 = {ref_mem[16'h3007], ref_mem[16'h3006], ref_mem[16'h3005], ref_mem[16'h3004]};
    do_req(1'b1, 2'b10, 1'b0, 16'h3003, 32'h11223344, lat, e, q, busy);
    if (MIS_EN) begin
      ref_mem[16'h3003] = 8'h44; ref_mem[16'h3004] = 8'h33;
      ref_mem[16'h3005] = 8'h22; ref_mem[16'h3006] = 8'h11;
      checks++;
      if (lat !== 2 || busy !== 1 || e !== 1'b0) begin
        failures++;
        $display("FAIL split_store: got lat=%0d busy=%0d err=%b, want 2/1/0", lat, busy, e);
      end
      do_req(1'b0, 2'b10, 1'b0, 16'h3003, 32'h0, lat, e, q, busy);
      checks++;
      if (lat !== 2 || q !== 32'h11223344 || e !== 1'b0) begin
        failures++;
        $display("FAIL split_load: got lat=%0d d=%h err=%b, want 2/11223344/0", lat, q, e);
      end
      do_req(1'b0, 2'b00, 1'b1, 16'h3004, 32'h0, lat, e, q, busy);
      checks++;
      if (q !== 32'h00000033) begin
        failures++;
        $display("FAIL split_byte_3004: got %h, want 00000033", q);
      end
      do_req(1'b0, 2'b00, 1'b1, 16'h3005, 32'h0, lat, e, q, busy);
      checks++;
      if (q !== 32'h00000022) begin
        failures++;
        $display("FAIL split_byte_3005: got %h, want 00000022", q);
      end
    end else begin
      checks++;
      if (lat !== 1 || e !== 1'b1 || q !== 32'h0) begin
        failures++;
        $display("FAIL misaligned_err: got lat=%0d err=%b d=%h, want 1/1/0", lat, e, q);
      end
      do_req(1'b0, 2'b10, 1'b0, 16'h3000, 32'h0, lat, e, q, busy);
      checks++;
      if (q !== w0) begin
        failures++;
        $display("FAIL misaligned_w0: got %h, want %h", q, w0);
      end
      do_req(1'b0, 2'b10, 1'b0, 16'h3004, 32'h0, lat, e, q, busy);
      checks++;
      if (q !== w1) begin
        failures++;
        $display("FAIL misaligned_w1: got %h, want %h", q, w1);
      end
    end
  endtask

  task automatic test_reserved;
    int lat, busy; logic e; logic [31:0] q;
    do_req(1'b0, 2'b11, 1'b0, 16'h0000, 32'h0, lat, e, q, busy);
    checks++;
    if (lat !== 1 || e !== 1'b1 || q !== 32'h0) begin
      failures++;
      $display("FAIL reserved_load: got lat=%0d err=%b d=%h, want 1/1/0", lat, e, q);
    end
    do_req(1'b1, 2'b11, 1'b0, 16'h0004, 32'hFFFF_FFFF, lat, e, q, busy);
    checks++;
    if (e !== 1'b1 || q !== 32'h0) begin
      failures++;
      $display("FAIL reserved_store: got err=%b d=%h, want 1/0", e, q);
    end
  endtask

  task automatic test_split_reset;
    int lat, busy, seen; logic e, ee; logic [31:0] q, eq; logic [15:0] a;
    if (MIS_EN) begin
      req_valid_i = 1'b1; w_rn_i = 1'b1; width_i = 2'b10; unsigned_i = 1'b0;
      addr_i = 16'hFFFE; data_i = 32'hAABBCCDD;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      checks++;
      if (req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL split_busy: got ready=%b, want 0", req_ready_o);
      end
      #2 reset_n = 1'b0;
      ref_mem[16'hFFFE] = 8'hDD; ref_mem[16'hFFFF] = 8'hCC;
      seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (rsp_valid_o) seen++;
      end
      reset_n = 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (rsp_valid_o) seen++;
      end
      checks++;
      if (seen !== 0) begin
        failures++;
        $display("FAIL split_reset_rsp: got %0d responses, want 0", seen);
      end
      checks++;
      if (req_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL split_reset_ready: got %b, want 1", req_ready_o);
      end
    end else begin
      do_req(1'b1, 2'b10, 1'b0, 16'hFFFE, 32'hAABBCCDD, lat, e, q, busy);
      checks++;
      if (e !== 1'b1) begin
        failures++;
        $display("FAIL wrap_err: got err=%b, want 1", e);
      end
    end
    for (int k = 0; k < 4; k++) begin
      a = (k < 2) ? 16'hFFFE + 16'(k) : 16'(k - 2);
      model(1'b0, 2'b00, 1'b1, a, 32'h0, ee, eq, lat);
      do_req(1'b0, 2'b00, 1'b1, a, 32'h0, lat, e, q, busy);
      checks++;
      if (q !== eq) begin
        failures++;
        $display("FAIL split_reset_byte @%h: got %h, want %h", a, q, eq);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, busy, elat; logic e, ee; logic [31:0] q, eq, d; logic [1:0] wd; logic [15:0] a;
    for (int k = 0; k < 10; k++) begin
      wd = 2'($urandom_range(0, 2));
      a = 16'($urandom_range(0, 15) * 4) + ((wd == 2'd0) ? 16'($urandom_range(0, 3)) :
                                            (wd == 2'd1) ? 16'h0002 : 16'h0000);
      d = $urandom;
      model(1'b1, wd, 1'b0, a, d, ee, eq, elat);
      do_req(1'b1, wd, 1'b0, a, d, lat, e, q, busy);
      model(1'b0, wd, 1'b1, a, 32'h0, ee, eq, elat);
      do_req(1'b0, wd, 1'b1, a, 32'h0, lat, e, q, busy);
      checks++;
      if (q !== eq || e !== 1'b0 || lat !== 1) begin
        failures++;
        $display("FAIL b2b @%h w%0d: got d=%h err=%b lat=%0d, want %h/0/1", a, wd, q, e, lat, eq);
      end
    end
  endtask

  task automatic test_random;
    int lat, busy, elat; logic e, ee, w, u; logic [31:0] q, eq, d; logic [1:0] wd; logic [15:0] a;
    for (int k = 0; k < 200; k++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      wd = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = (($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFC0) + 16'($urandom_range(0, 63));
      d  = $urandom;
      model(w, wd, u, a, d, ee, eq, elat);
      do_req(w, wd, u, a, d, lat, e, q, busy);
      checks++;
      if (e !== ee || q !== eq || lat !== elat || busy !== elat - 1) begin
        failures++;
        $display("FAIL random #%0d w=%b wd=%0d u=%b @%h: got err=%b d=%h lat=%0d busy=%0d, want err=%b d=%h lat=%0d",
                 k, w, wd, u, a, e, q, lat, busy, ee, eq, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_word();
    test_byte();
    test_misaligned();
    test_reserved();
    test_split_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
